// File: rtl/sine_dds_pkg.sv
// Shared definitions for the stereo sine DDS source: default geometry and FSM encoding.
package sine_dds_pkg;
  localparam int PHASE_W_DEF = 24;
  localparam int LUT_AW_DEF  = 8;
  localparam int DATA_W_DEF  = 16;
  localparam int ATTEN_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR_L = 2'd1,
    ST_ADDR_R = 2'd2,
    ST_SIGN   = 2'd3
  } dds_state_e;
endpackage

// File: rtl/sine_dds_if.sv
// Request/sample bus between the I2S frame logic (master) and the DDS source (slave).
interface sine_dds_if
  import sine_dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  logic                      en;
  logic                      req;
  logic [PHASE_W-1:0]        tuning_word;
  logic [PHASE_W-1:0]        phase_ofs;
  logic [ATTEN_W-1:0]        atten;
  logic                      ovr_clr;
  logic                      busy;
  logic                      sample_valid;
  logic signed [DATA_W-1:0]  sample_l;
  logic signed [DATA_W-1:0]  sample_r;
  logic                      overrun;

  modport master (
    output en, req, tuning_word, phase_ofs, atten, ovr_clr,
    input  busy, sample_valid, sample_l, sample_r, overrun
  );
  modport slave (
    input  en, req, tuning_word, phase_ofs, atten, ovr_clr,
    output busy, sample_valid, sample_l, sample_r, overrun
  );
endinterface

// File: rtl/sine_dds_source_qlut.sv
// Quarter-wave sine magnitude ROM, one-cycle registered read, shared by L and R.
// Contents are built at elaboration: entry i = round(FS*sin(pi/2*(i+0.5)/2^LUT_AW)).
module sine_qlut #(
  parameter int LUT_AW = 8,
  parameter int MAG_W  = 15
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr_i,
  output logic [MAG_W-1:0]  mag_o
);
  localparam int DEPTH = 1 << LUT_AW;

  // Q30 fixed-point Taylor series; error is far below half an output LSB.
  function automatic logic [DEPTH*MAG_W-1:0] build_rom();
    logic [DEPTH*MAG_W-1:0] r;
    longint pi_q30, x, x2, term, sum, fs;
    pi_q30 = 64'sd3373259426;
    fs     = (64'sd1 <<< MAG_W) - 64'sd1;
    r      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      x    = (pi_q30 * longint'(2*i+1)) >>> (LUT_AW + 2);
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int k = 1; k <= 7; k++) begin
        term = -((term * x2) >>> 30) / longint'((2*k) * (2*k+1));
        sum  = sum + term;
      end
      r[i*MAG_W +: MAG_W] = MAG_W'((sum * fs + (64'sd1 <<< 29)) >>> 30);
    end
    return r;
  endfunction

  localparam logic [DEPTH*MAG_W-1:0] ROM = build_rom();

  always_ff @(posedge clk) begin
    mag_o <= ROM[int'(addr_i)*MAG_W +: MAG_W];
  end
endmodule

// File: rtl/sine_dds_source.sv
// Stereo DDS: phase accumulator feeding a time-multiplexed quarter-wave LUT,
// one signed L/R pair per accepted request, four clocks per pair.
module sine_dds_source
  import sine_dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int LUT_AW  = LUT_AW_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  sine_dds_if.slave  bus
);
  localparam int MAG_W  = DATA_W - 1;
  localparam int PH_TOP = LUT_AW + 2;   // quadrant + LUT address; lower phase bits truncated

  dds_state_e               state_q, state_d;
  logic [PHASE_W-1:0]       acc_q;
  logic [PH_TOP-1:0]        ph_l_q, ph_r_q;
  logic [ATTEN_W-1:0]       atten_q;
  logic                     en_q;
  logic [MAG_W-1:0]         mag_l_q, mag;
  logic signed [DATA_W-1:0] sl_q, sr_q;
  logic                     vld_q, ovr_q;
  logic                     busy_c, accept;
  logic [LUT_AW-1:0]        rom_addr;

  function automatic logic [LUT_AW-1:0] lut_addr(input logic [PH_TOP-1:0] p);
    return p[LUT_AW] ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] shape(input logic neg,
                                                     input logic [MAG_W-1:0] m,
                                                     input logic [ATTEN_W-1:0] sh);
    logic signed [DATA_W-1:0] v;
    v = $signed({1'b0, m});
    if (neg) v = -v;
    return v >>> sh;
  endfunction

  assign accept = bus.req && (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.req) state_d = ST_ADDR_L;
      ST_ADDR_L: state_d = ST_ADDR_R;
      ST_ADDR_R: state_d = ST_SIGN;
      ST_SIGN:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_c   = (state_q != ST_IDLE);
    rom_addr = (state_q == ST_ADDR_L) ? lut_addr(ph_l_q) : lut_addr(ph_r_q);
  end

  sine_qlut #(.LUT_AW(LUT_AW), .MAG_W(MAG_W)) u_lut (
    .clk    (clk),
    .addr_i (rom_addr),
    .mag_o  (mag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      ph_l_q  <= '0;
      ph_r_q  <= '0;
      atten_q <= '0;
      en_q    <= 1'b0;
      mag_l_q <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (!bus.en)     acc_q <= '0;
      else if (accept) acc_q <= acc_q + bus.tuning_word;
      if (accept) begin
        ph_l_q  <= acc_q[PHASE_W-1 -: PH_TOP];
        ph_r_q  <= PH_TOP'((acc_q + bus.phase_ofs) >> (PHASE_W - PH_TOP));
        atten_q <= bus.atten;
        en_q    <= bus.en;
      end
      if (state_q == ST_ADDR_R) mag_l_q <= mag;
      // In SIGN the ROM output already holds the right-channel magnitude.
      if (state_q == ST_SIGN) begin
        vld_q <= 1'b1;
        sl_q  <= en_q ? shape(ph_l_q[PH_TOP-1], mag_l_q, atten_q) : '0;
        sr_q  <= en_q ? shape(ph_r_q[PH_TOP-1], mag,     atten_q) : '0;
      end
      if (bus.req && busy_c) ovr_q <= 1'b1;
      else if (bus.ovr_clr)  ovr_q <= 1'b0;
    end
  end

  assign bus.busy         = busy_c;
  assign bus.sample_valid = vld_q;
  assign bus.sample_l     = sl_q;
  assign bus.sample_r     = sr_q;
  assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_sine_dds_source.sv
// Directed bench for sine_dds_source: hand-computed sample values, timing and overrun checks.
module tb_sine_dds_source;
  import sine_dds_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  sine_dds_if #(.PHASE_W(24), .DATA_W(16)) bus ();

  sine_dds_source #(.PHASE_W(24), .LUT_AW(8), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request and check the pair arrives exactly four clocks later.
  task automatic pair(input string tag, input int el, input int er);
    bus.req = 1'b1;
    step(1);
    bus.req = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1);
    step(2);
    chk({tag, "_early"}, bus.sample_valid, 0);
    step(1);
    chk({tag, "_valid"}, bus.sample_valid, 1);
    chk({tag, "_l"}, bus.sample_l, el);
    chk({tag, "_r"}, bus.sample_r, er);
  endtask

  initial begin
    rst             = 1'b1;
    bus.en          = 1'b1;
    bus.req         = 1'b0;
    bus.tuning_word = 24'h400000;
    bus.phase_ofs   = 24'h0;
    bus.atten       = 4'd0;
    bus.ovr_clr     = 1'b0;
    step(2);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_valid", bus.sample_valid, 0);
    chk("rst_l",     bus.sample_l, 0);
    chk("rst_r",     bus.sample_r, 0);
    chk("rst_ovr",   bus.overrun, 0);
    rst = 1'b0;
    step(1);

    // quarter-turn steps, R == L
    pair("t1a", 101, 101);       step(4);
    pair("t1b", 32767, 32767);   step(4);
    pair("t1c", -101, -101);     step(4);
    pair("t1d", -32767, -32767); step(4);

    // R leads by a quarter turn
    bus.phase_ofs = 24'h400000;
    pair("t2a", 101, 32767);
    pair("t2b", 32767, -101);
    step(2);

    // second req two clocks later is dropped
    bus.req = 1'b1; step(1);
    bus.req = 1'b0; step(1);
    bus.req = 1'b1; step(1);
    bus.req = 1'b0;
    chk("t3_ovr_set", bus.overrun, 1);
    step(1);
    chk("t3_valid", bus.sample_valid, 1);
    chk("t3_l", bus.sample_l, -101);
    chk("t3_r", bus.sample_r, -32767);
    step(1);
    chk("t3_one_valid", bus.sample_valid, 0);
    chk("t3_no_start", bus.busy, 0);
    step(3);
    chk("t3_still_one", bus.sample_valid, 0);
    bus.ovr_clr = 1'b1; step(1); bus.ovr_clr = 1'b0;
    chk("t3_ovr_clr", bus.overrun, 0);
    bus.req = 1'b1; step(1);
    bus.req = 1'b0; step(1);
    bus.req = 1'b1; bus.ovr_clr = 1'b1; step(1);
    bus.req = 1'b0; bus.ovr_clr = 1'b0;
    chk("t3_set_wins", bus.overrun, 1);
    step(1);
    chk("t3b_l", bus.sample_l, -32767);
    chk("t3b_r", bus.sample_r, 101);
    bus.ovr_clr = 1'b1; step(1); bus.ovr_clr = 1'b0;
    step(2);

    // attenuation by 16, floor rounding on negatives
    bus.phase_ofs = 24'h0;
    bus.atten     = 4'd4;
    pair("t4a", 6, 6);
    pair("t4b", 2047, 2047);
    pair("t4c", -7, -7);
    pair("t4d", -2048, -2048);

    // near-full-scale tuning word: phase steps backwards by one LSB
    bus.atten       = 4'd0;
    bus.tuning_word = 24'hFFFFFF;
    pair("t5a", 101, 101);
    pair("t5b", -101, -101);
    pair("t5c", -101, -101);

    // disabled: zero samples; enabling restarts at phase 0 / phase_ofs
    bus.en = 1'b0;
    step(1);
    pair("en0", 0, 0);
    bus.en          = 1'b1;
    bus.tuning_word = 24'h400000;
    bus.phase_ofs   = 24'h400000;
    pair("en1", 101, 32767);
    step(2);

    // reset in the middle of a request
    bus.phase_ofs = 24'h0;
    bus.req = 1'b1; step(1);
    bus.req = 1'b0; step(1);
    rst = 1'b1;
    #1;
    chk("t6_valid", bus.sample_valid, 0);
    chk("t6_l",     bus.sample_l, 0);
    chk("t6_r",     bus.sample_r, 0);
    chk("t6_busy",  bus.busy, 0);
    rst = 1'b0;
    step(1);
    chk("t6_no_pulse_a", bus.sample_valid, 0);
    step(2);
    chk("t6_no_pulse_b", bus.sample_valid, 0);
    pair("t6_after", 101, 101);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
